// File: rtl/sdp_inv_pipe_if.sv
// +----------------------------------------------------------------------------+
// | Module : sdp_inv_pipe_if                                                   |
// | Brief  : Handshake/data bundle for sdp_inv_pipe (SDP_INV_CHECK_EN adds     |
// |          the a_ref/mismatch/mis_cnt self-check signals).                   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface sdp_inv_pipe_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 ctl_1;
  logic                 ctl_2;
  logic [WIDTH-1:0]     n;
  logic [WIDTH-1:0]     b;
  logic [WIDTH-1:0]     c;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     a_out;
  logic [CNT_WIDTH-1:0] done_cnt;
`ifdef SDP_INV_CHECK_EN
  logic [WIDTH-1:0]     a_ref;
  logic                 mismatch;
  logic [CNT_WIDTH-1:0] mis_cnt;

  modport master (
    output in_valid, ctl_1, ctl_2, n, b, c, out_ready, a_ref,
    input  in_ready, out_valid, a_out, done_cnt, mismatch, mis_cnt
  );
  modport slave (
    input  in_valid, ctl_1, ctl_2, n, b, c, out_ready, a_ref,
    output in_ready, out_valid, a_out, done_cnt, mismatch, mis_cnt
  );
`else
  modport master (
    output in_valid, ctl_1, ctl_2, n, b, c, out_ready,
    input  in_ready, out_valid, a_out, done_cnt
  );
  modport slave (
    input  in_valid, ctl_1, ctl_2, n, b, c, out_ready,
    output in_ready, out_valid, a_out, done_cnt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/sdp_inv_pipe.sv
// +----------------------------------------------------------------------------+
// | Module : sdp_inv_pipe                                                      |
// | Brief  : 3-stage inverse of the add/sub datapath, recovers a from n.       |
// |          Optional self-check via macro SDP_INV_CHECK_EN.                   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdp_inv_pipe #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  sdp_inv_pipe_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 s1_valid_q, s1_valid_d, s1_ctl1_q, s1_ctl1_d, s1_ctl2_q, s1_ctl2_d;
  logic [WIDTH-1:0]     s1_n_q, s1_n_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
  logic                 s2_valid_q, s2_valid_d, s2_ctl1_q, s2_ctl1_d;
  logic [WIDTH-1:0]     s2_m_q, s2_m_d, s2_b_q, s2_b_d;
  logic                 s3_valid_q, s3_valid_d;
  logic [WIDTH-1:0]     s3_a_q, s3_a_d;
  logic [CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;

  logic             s1_rdy, s2_rdy, s3_rdy, out_fire;
  logic [WIDTH-1:0] m_calc, a_calc;

  // Ready ripples back combinationally so a draining output frees the whole chain.
  assign s3_rdy   = !s3_valid_q || bus.out_ready;
  assign s2_rdy   = !s2_valid_q || s3_rdy;
  assign s1_rdy   = !s1_valid_q || s2_rdy;
  assign out_fire = s3_valid_q && bus.out_ready;

  assign m_calc = s1_ctl2_q ? (s1_n_q - s1_c_q) : (s1_n_q + s1_c_q);
  assign a_calc = s2_ctl1_q ? (s2_m_q - s2_b_q) : (s2_m_q + s2_b_q);

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_ctl1_d  = s1_ctl1_q;
    s1_ctl2_d  = s1_ctl2_q;
    s1_n_d     = s1_n_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s2_valid_d = s2_valid_q;
    s2_ctl1_d  = s2_ctl1_q;
    s2_m_d     = s2_m_q;
    s2_b_d     = s2_b_q;
    s3_valid_d = s3_valid_q;
    s3_a_d     = s3_a_q;
    done_cnt_d = done_cnt_q;
    if (s1_rdy) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_ctl1_d = bus.ctl_1;
        s1_ctl2_d = bus.ctl_2;
        s1_n_d    = bus.n;
        s1_b_d    = bus.b;
        s1_c_d    = bus.c;
      end
    end
    if (s2_rdy) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_ctl1_d = s1_ctl1_q;
        s2_m_d    = m_calc;
        s2_b_d    = s1_b_q;
      end
    end
    if (s3_rdy) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_a_d = a_calc;
      end
    end
    if (out_fire) begin
      done_cnt_d = done_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_ctl1_q  <= 1'b0;
      s1_ctl2_q  <= 1'b0;
      s1_n_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_ctl1_q  <= 1'b0;
      s2_m_q     <= '0;
      s2_b_q     <= '0;
      s3_valid_q <= 1'b0;
      s3_a_q     <= '0;
      done_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_ctl1_q  <= s1_ctl1_d;
      s1_ctl2_q  <= s1_ctl2_d;
      s1_n_q     <= s1_n_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s2_valid_q <= s2_valid_d;
      s2_ctl1_q  <= s2_ctl1_d;
      s2_m_q     <= s2_m_d;
      s2_b_q     <= s2_b_d;
      s3_valid_q <= s3_valid_d;
      s3_a_q     <= s3_a_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign bus.in_ready  = s1_rdy;
  assign bus.out_valid = s3_valid_q;
  assign bus.a_out     = s3_a_q;
  assign bus.done_cnt  = done_cnt_q;

`ifdef SDP_INV_CHECK_EN
  logic [WIDTH-1:0]     s1_ref_q, s1_ref_d, s2_ref_q, s2_ref_d, s3_ref_q, s3_ref_d;
  logic                 mismatch_q, mismatch_d;
  logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

  // Reference value travels with its transaction, using the same stage enables.
  always_comb begin
    s1_ref_d   = s1_ref_q;
    s2_ref_d   = s2_ref_q;
    s3_ref_d   = s3_ref_q;
    mismatch_d = mismatch_q;
    mis_cnt_d  = mis_cnt_q;
    if (s1_rdy && bus.in_valid) s1_ref_d = bus.a_ref;
    if (s2_rdy && s1_valid_q)   s2_ref_d = s1_ref_q;
    if (s3_rdy && s2_valid_q)   s3_ref_d = s2_ref_q;
    if (out_fire && (s3_a_q != s3_ref_q)) begin
      mismatch_d = 1'b1;
      if (mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_ref_q   <= '0;
      s2_ref_q   <= '0;
      s3_ref_q   <= '0;
      mismatch_q <= 1'b0;
      mis_cnt_q  <= '0;
    end else begin
      s1_ref_q   <= s1_ref_d;
      s2_ref_q   <= s2_ref_d;
      s3_ref_q   <= s3_ref_d;
      mismatch_q <= mismatch_d;
      mis_cnt_q  <= mis_cnt_d;
    end
  end

  assign bus.mismatch = mismatch_q;
  assign bus.mis_cnt  = mis_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sdp_inv_pipe.sv
// +----------------------------------------------------------------------------+
// | Module : tb_sdp_inv_pipe                                                   |
// | Brief  : Randomized bench; operand a is chosen first and pushed through    |
// |          the forward add/sub function, so a_out must return it.            |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sdp_inv_pipe;
  localparam int W  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sdp_inv_pipe_if #(.WIDTH(W), .CNT_WIDTH(CW)) bus ();
  sdp_inv_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           done_model = 0;
  logic [W-1:0] exp_q[$];
  int           acc_q[$];
  logic [W-1:0] pend_a;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_a = '0;
  bit           last_acc = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
  endtask

  // One clock cycle: check outputs against the queue model, book the handshakes.
  task automatic step();
    bit in_fire, out_fire;
    @(negedge clk);
    chk("in_ready", bus.in_ready, (exp_q.size() < 3 || bus.out_ready) ? 1 : 0);
    chk("out_valid", bus.out_valid, (acc_q.size() > 0 && cyc - acc_q[0] >= 3) ? 1 : 0);
    chk("done_cnt", bus.done_cnt, done_model);
    if (prev_stall) chk("hold_a_out", bus.a_out, prev_a);
    in_fire  = bus.in_valid && bus.in_ready;
    out_fire = bus.out_valid && bus.out_ready;
    if (out_fire) begin
      if (exp_q.size() > 0) begin
        chk("a_out", bus.a_out, exp_q[0]);
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      done_model = (done_model + 1) % (1 << CW);
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_a     = bus.a_out;
    if (in_fire) begin
      exp_q.push_back(pend_a);
      acc_q.push_back(cyc);
    end
    last_acc = in_fire;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input bit c1, input bit c2, input logic [W-1:0] nn, input logic [W-1:0] bb,
                      input logic [W-1:0] cc, input logic [W-1:0] aa, input logic [W-1:0] rr);
    bus.in_valid = 1'b1;
    bus.ctl_1    = c1;
    bus.ctl_2    = c2;
    bus.n        = nn;
    bus.b        = bb;
    bus.c        = cc;
    pend_a       = aa;
`ifdef SDP_INV_CHECK_EN
    bus.a_ref    = rr;
`else
    if (rr != aa) pend_a = aa;
`endif
  endtask

  task automatic rand_tx();
    logic [W-1:0] a, b, c, m, n;
    bit c1, c2;
    a  = W'($urandom);
    b  = W'($urandom);
    c  = W'($urandom);
    c1 = 1'($urandom);
    c2 = 1'($urandom);
    m  = c1 ? a + b : a - b;
    n  = c2 ? m + c : m - c;
    load(c1, c2, n, b, c, a, a);
  endtask

  task automatic send(input bit c1, input bit c2, input logic [W-1:0] nn, input logic [W-1:0] bb,
                      input logic [W-1:0] cc, input logic [W-1:0] aa, input logic [W-1:0] rr);
    int g = 0;
    load(c1, c2, nn, bb, cc, aa, rr);
    do begin
      step();
      g++;
    end while (!last_acc && g < 50);
    chk("accept", last_acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() > 0 && g < 20) begin
      step();
      g++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, stall, drop_acc;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.ctl_1     = 1'b0;
    bus.ctl_2     = 1'b0;
    bus.n         = '0;
    bus.b         = '0;
    bus.c         = '0;
`ifdef SDP_INV_CHECK_EN
    bus.a_ref     = '0;
`endif
    pend_a = '0;

    // Reset with in_valid asserted
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_a_out", bus.a_out, 0);
    chk("rst_done_cnt", bus.done_cnt, 0);
    bus.in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed: basic and wrap-around cases
    send(1'b1, 1'b0, 8'd9, 8'd3, 8'd4, 8'd10, 8'd10);
    drain();
    chk("basic_done", bus.done_cnt, 1);
    send(1'b1, 1'b1, 8'd9, 8'd10, 8'd5, 8'd250, 8'd250);
    send(1'b0, 1'b0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1);
    drain();
    chk("wrap_done", bus.done_cnt, 3);

    // Backpressure: 5-deep stream, output stalled for 4 cycles once valid
    sent = 0; stall = 0; drop_acc = -1;
    bus.out_ready = 1'b1;
    rand_tx();
    for (int k = 0; k < 60 && (sent < 5 || exp_q.size() > 0); k++) begin
      if (bus.out_valid && stall < 4) begin
        bus.out_ready = 1'b0;
        stall++;
      end else begin
        bus.out_ready = 1'b1;
      end
      step();
      if (bus.in_valid) begin
        if (last_acc) begin
          sent++;
          if (sent < 5) rand_tx();
          else bus.in_valid = 1'b0;
        end else if (drop_acc < 0) begin
          drop_acc = sent;
        end
      end
    end
    chk("bp_accepts_before_drop", drop_acc, 3);
    chk("bp_sent", sent, 5);
    chk("bp_empty", exp_q.size(), 0);
    chk("bp_done", bus.done_cnt, 8);

    // Random traffic with random backpressure
    bus.in_valid = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!bus.in_valid || last_acc) begin
        if ($urandom_range(0, 9) < 7) rand_tx();
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    drain();

`ifdef SDP_INV_CHECK_EN
    chk("chk_clean_mismatch", bus.mismatch, 0);
    chk("chk_clean_mis_cnt", bus.mis_cnt, 0);
    send(1'b1, 1'b0, 8'd9, 8'd3, 8'd4, 8'd10, 8'd11);
    drain();
    chk("chk_mismatch", bus.mismatch, 1);
    chk("chk_mis_cnt", bus.mis_cnt, 1);
    send(1'b1, 1'b0, 8'd9, 8'd3, 8'd4, 8'd10, 8'd10);
    drain();
    chk("chk_sticky", bus.mismatch, 1);
    chk("chk_mis_cnt_keep", bus.mis_cnt, 1);
`endif

    // Mid-flight asynchronous reset with 3 transactions in the pipe
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) send(1'b1, 1'b0, 8'd9, 8'd3, 8'd4, 8'd10, 8'd10);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_done_cnt", bus.done_cnt, 0);
    chk("mid_rst_a_out", bus.a_out, 0);
`ifdef SDP_INV_CHECK_EN
    chk("mid_rst_mismatch", bus.mismatch, 0);
`endif
    exp_q.delete();
    acc_q.delete();
    done_model = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
